uart_xmit_engine: RTL

//  Parametrised UART transmitter: control FSM plus datapath (holding reg, shift reg, parity, baud timing).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_xmit_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        STOP
    } state_t;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;
    localparam logic [1:0] PARITY_MARK = 2'b11;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud timer: counts Clock cycles within one serial bit and flags the final cycle.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            cnt <= '0;
        else if (clr || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_xmit_engine.sv
// UART transmitter: one-entry holding buffer, shift register, per-frame parity/stop
// configuration and a registered-output control FSM driving TxD.
module uart_xmit_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 WR,
    input  logic [DATA_BITS-1:0] Din,
    input  logic [1:0]           ParityMode,
    input  logic                 TwoStop,
    output logic                 TxD,
    output logic                 TxRDY,
    output logic                 Busy,
    output logic                 Overrun
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t state, state_n;

    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;
    logic [1:0]           hold_pmode;
    logic                 hold_two;

    logic [DATA_BITS-1:0] sh;
    logic [1:0]           cur_pmode;
    logic                 cur_two;
    logic                 par_bit, par_calc;

    logic [BW-1:0] bitcnt;
    logic          bit_end, baud_clr, accept, xfer, txd_n, stop_last;

    assign accept    = WR & ~hold_full;
    assign TxRDY     = ~hold_full;
    assign Busy      = (state != IDLE);
    assign stop_last = (bitcnt == {{(BW-1){1'b0}}, cur_two});
    // Counter is held at zero while idle so START always gets a full bit.
    assign baud_clr  = (state_n != state) || (state == IDLE);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .Clock   (Clock),
        .Reset   (Reset),
        .clr     (baud_clr),
        .bit_end (bit_end)
    );

    always_comb begin
        par_calc = 1'b0;
        case (hold_pmode)
            PARITY_EVEN: par_calc = ^hold_data;
            PARITY_ODD:  par_calc = ~^hold_data;
            PARITY_MARK: par_calc = 1'b1;
            default:     par_calc = 1'b0;
        endcase
    end

    // TxD is registered: txd_n is the line level for the cycle after the edge.
    always_comb begin
        state_n = state;
        txd_n   = TxD;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (hold_full) begin
                    state_n = START;
                    txd_n   = 1'b0;
                    xfer    = 1'b1;
                end
            end
            START: if (bit_end) begin
                state_n = SHIFT;
                txd_n   = sh[0];
            end
            SHIFT: if (bit_end) begin
                if (bitcnt == LAST_BIT) begin
                    if (cur_pmode != PARITY_NONE) begin
                        state_n = PARITY;
                        txd_n   = par_bit;
                    end else begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end
                end else begin
                    txd_n = sh[1];
                end
            end
            PARITY: if (bit_end) begin
                state_n = STOP;
                txd_n   = 1'b1;
            end
            STOP: if (bit_end && stop_last) begin
                if (hold_full) begin
                    state_n = START;
                    txd_n   = 1'b0;
                    xfer    = 1'b1;
                end else begin
                    state_n = IDLE;
                    txd_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            TxD     <= 1'b1;
            Overrun <= 1'b0;
        end else begin
            state   <= state_n;
            TxD     <= txd_n;
            Overrun <= WR & hold_full;
        end
    end

    // accept and xfer are mutually exclusive: accept needs the buffer empty.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hold_full  <= 1'b0;
            hold_data  <= '0;
            hold_pmode <= PARITY_NONE;
            hold_two   <= 1'b0;
        end else if (accept) begin
            hold_full  <= 1'b1;
            hold_data  <= Din;
            hold_pmode <= ParityMode;
            hold_two   <= TwoStop;
        end else if (xfer) begin
            hold_full  <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sh        <= '0;
            cur_pmode <= PARITY_NONE;
            cur_two   <= 1'b0;
            par_bit   <= 1'b0;
        end else if (xfer) begin
            sh        <= hold_data;
            cur_pmode <= hold_pmode;
            cur_two   <= hold_two;
            par_bit   <= par_calc;
        end else if (state == SHIFT && bit_end) begin
            sh        <= sh >> 1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            bitcnt <= '0;
        else if (state_n != state)
            bitcnt <= '0;
        else if (bit_end)
            bitcnt <= bitcnt + 1'b1;
    end

endmodule
